// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the multicycle memory-access sequencer:
// op and state encodings plus small decode helpers.
package mem_access_seq_pkg;

    localparam int DEF_TIMEOUT_CYC = 15;

    typedef enum logic [2:0] {
        OP_LW = 3'd0,
        OP_LH = 3'd1,
        OP_LB = 3'd2,
        OP_SW = 3'd3,
        OP_SH = 3'd4,
        OP_SB = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_SB;
    endfunction

    function automatic logic op_is_load(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
    endfunction

    // Memory is word addressed, so the byte offset is simply discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Bus bundles around the sequencer: the datapath request/response
// handshake and the shared data-memory strobe interface.
interface mem_access_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

interface mem_access_seq_mem_if;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_access_seq_store_merge.sv
// Combinational word shaper: merges store data into a read word for SH/SB
// and extracts zero-extended load results for LW/LH/LB.
module mem_access_seq_store_merge
    import mem_access_seq_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_LW:   result = rd_word;
            OP_LH:   result = {16'b0, rd_word[15:0]};
            OP_LB:   result = {24'b0, rd_word[7:0]};
            OP_SW:   result = wdata;
            OP_SH:   result = {rd_word[31:16], wdata[15:0]};
            OP_SB:   result = {rd_word[31:8], wdata[7:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle memory-access sequencer for LW/LH/LB/SW/SH/SB; partial stores
// are done as read-modify-write on the shared word-wide data memory.
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_seq_if.slave      req,
    mem_access_seq_mem_if.master mem
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] wr_data_q;
    logic        err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0] shaped;
    logic        expired;

    // One shaper serves both the SH/SB merge and the load extraction,
    // since those never happen in the same state.
    mem_access_seq_store_merge u_merge (
        .op      (op_q),
        .rd_word (word_q),
        .wdata   (wdata_q),
        .result  (shaped)
    );

    assign expired = !mem.mem_ack && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    if (!op_is_legal(req.req_op))
                        state_d = S_RESP;
                    else if (req.req_op == OP_SW)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (mem.mem_ack)
                    state_d = op_is_load(op_q) ? S_RESP : S_MERGE;
                else if (expired)
                    state_d = S_RESP;
            end
            S_MERGE: state_d = S_WR;
            S_WR: begin
                if (mem.mem_ack || expired)
                    state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and responses decode straight from the state so a reset or
    // completion takes them down on the very next cycle.
    always_comb begin
        req.req_ready  = (state_q == S_IDLE);
        mem.mem_rd     = (state_q == S_RD);
        mem.mem_wr     = (state_q == S_WR);
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        req.resp_valid = (state_q == S_RESP);
        req.resp_err   = (state_q == S_RESP) && err_q;
        req.resp_rdata = '0;
        if ((state_q == S_RD) || (state_q == S_WR))
            mem.mem_addr = addr_q;
        if (state_q == S_WR)
            mem.mem_wdata = wr_data_q;
        if ((state_q == S_RESP) && op_is_load(op_q) && !err_q)
            req.resp_rdata = shaped;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LW;
            addr_q    <= '0;
            wdata_q   <= '0;
            word_q    <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req.req_valid) begin
                        op_q      <= req.req_op;
                        addr_q    <= align_word(req.req_addr);
                        wdata_q   <= req.req_wdata;
                        wr_data_q <= req.req_wdata;
                        err_q     <= !op_is_legal(req.req_op);
                        cnt_q     <= '0;
                    end
                end
                S_RD: begin
                    if (mem.mem_ack) begin
                        word_q <= mem.mem_rdata;
                        cnt_q  <= '0;
                    end else if (expired) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_MERGE: begin
                    wr_data_q <= shaped;
                    cnt_q     <= '0;
                end
                S_WR: begin
                    if (mem.mem_ack)
                        cnt_q <= '0;
                    else if (expired)
                        err_q <= 1'b1;
                    else
                        cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: a simple memory responder plus
// response and write scoreboards fed as requests are issued.
module tb_mem_access_seq;
    import mem_access_seq_pkg::*;

    localparam int TO = 15;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          accept_cycle;
        int          lat;
    } exp_resp_t;

    logic clk;
    logic reset;
    int   cycle_cnt;
    int   checks;
    int   errors;

    mem_access_seq_if     req_bus ();
    mem_access_seq_mem_if mem_bus ();

    mem_access_seq #(.TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req_bus),
        .mem   (mem_bus)
    );

    exp_resp_t   resp_q[$];
    logic [31:0] write_q[$];

    logic [31:0] mem_word;
    logic [31:0] exp_mem_addr;
    int          ack_delay;
    logic        ack_rd_en;
    logic        ack_wr_en;
    int          run_len;
    logic        run_is_rd;
    int          last_rd_len;
    int          last_wr_len;
    int          rd_cycles;
    int          wr_cycles;
    int          wr_acks;
    int          resp_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request starting at a negedge; returns the accept cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int lat, input logic expect_resp,
                                 output int acc);
        exp_resp_t e;
        int guard;
        req_bus.req_valid = 1'b1;
        req_bus.req_op    = op;
        req_bus.req_addr  = addr;
        req_bus.req_wdata = wdata;
        guard = 0;
        while (!req_bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept", 32'(req_bus.req_ready), 32'd1);
        acc = cycle_cnt;
        if (expect_resp) begin
            e.rdata = exp_rdata;
            e.err = exp_err;
            e.accept_cycle = acc;
            e.lat = lat;
            resp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
    endtask

    task automatic waitResp(input int n);
        int guard;
        guard = 0;
        while (resp_total < n && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("resp_arrived", 32'(resp_total >= n), 32'd1);
        @(negedge clk);
    endtask

    // Memory responder: acks after ack_delay extra strobe cycles.
    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        run_len = 0;
        run_is_rd = 1'b0;
        forever begin
            @(negedge clk);
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = '0;
            if (mem_bus.mem_rd || mem_bus.mem_wr) begin
                checkOutput("strobe_excl", 32'(mem_bus.mem_rd & mem_bus.mem_wr), 32'd0);
                run_len++;
                run_is_rd = mem_bus.mem_rd;
                if (mem_bus.mem_rd) rd_cycles++;
                if (mem_bus.mem_wr) wr_cycles++;
                if ((mem_bus.mem_rd ? ack_rd_en : ack_wr_en) && run_len == ack_delay + 1) begin
                    mem_bus.mem_ack = 1'b1;
                    checkOutput("mem_addr", mem_bus.mem_addr, exp_mem_addr);
                    if (mem_bus.mem_rd) begin
                        mem_bus.mem_rdata = mem_word;
                        last_rd_len = run_len;
                    end else begin
                        wr_acks++;
                        last_wr_len = run_len;
                        checkOutput("write_pending", 32'(write_q.size() != 0), 32'd1);
                        if (write_q.size() != 0)
                            checkOutput("write_data", mem_bus.mem_wdata, write_q.pop_front());
                        mem_word = mem_bus.mem_wdata;
                    end
                    run_len = 0;
                end
            end else if (run_len != 0) begin
                if (run_is_rd) last_rd_len = run_len;
                else last_wr_len = run_len;
                run_len = 0;
            end
        end
    end

    // Response scoreboard.
    initial begin
        exp_resp_t e;
        forever begin
            @(negedge clk);
            if (req_bus.resp_valid) begin
                resp_total++;
                checkOutput("resp_pending", 32'(resp_q.size() != 0), 32'd1);
                if (resp_q.size() != 0) begin
                    e = resp_q.pop_front();
                    checkOutput("resp_rdata", req_bus.resp_rdata, e.rdata);
                    checkOutput("resp_err", 32'(req_bus.resp_err), 32'(e.err));
                    checkOutput("resp_latency", 32'(cycle_cnt - e.accept_cycle + 1), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        int acc, acc2, rd0, wr0, wa0, rt0, guard;
        cycle_cnt = 0;
        checks = 0;
        errors = 0;
        resp_total = 0;
        rd_cycles = 0;
        wr_cycles = 0;
        wr_acks = 0;
        last_rd_len = 0;
        last_wr_len = 0;
        ack_delay = 0;
        ack_rd_en = 1'b1;
        ack_wr_en = 1'b1;
        mem_word = '0;
        exp_mem_addr = '0;
        req_bus.req_valid = 1'b0;
        req_bus.req_op    = '0;
        req_bus.req_addr  = '0;
        req_bus.req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(req_bus.req_ready), 32'd1);
        checkOutput("rst_rd", 32'(mem_bus.mem_rd), 32'd0);
        checkOutput("rst_wr", 32'(mem_bus.mem_wr), 32'd0);
        checkOutput("rst_resp_valid", 32'(req_bus.resp_valid), 32'd0);
        checkOutput("rst_addr", mem_bus.mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_bus.mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] SW word store");
        rd0 = rd_cycles; wr0 = wr_cycles;
        exp_mem_addr = 32'h10;
        write_q.push_back(32'hDEADBEEF);
        applyStimulus(OP_SW, 32'h0000_0013, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b1, acc);
        waitResp(1);
        checkOutput("sw_no_rd", 32'(rd_cycles - rd0), 32'd0);
        checkOutput("sw_wr_cycles", 32'(wr_cycles - wr0), 32'd1);

        $display("[TB] SB read-modify-write");
        mem_word = 32'h11223344;
        exp_mem_addr = 32'h40;
        write_q.push_back(32'h112233AB);
        applyStimulus(OP_SB, 32'h0000_0041, 32'h0000_00AB, 32'h0, 1'b0, 5, 1'b1, acc);
        waitResp(2);

        $display("[TB] SH with delayed acks");
        ack_delay = 4;
        mem_word = 32'hAABBCCDD;
        exp_mem_addr = 32'h80;
        write_q.push_back(32'hAABB1234);
        applyStimulus(OP_SH, 32'h0000_0082, 32'hFFFF_1234, 32'h0, 1'b0, 13, 1'b1, acc);
        waitResp(3);
        checkOutput("sh_rd_len", 32'(last_rd_len), 32'd5);
        checkOutput("sh_wr_len", 32'(last_wr_len), 32'd5);
        checkOutput("sh_mem_word", mem_word, 32'hAABB1234);

        $display("[TB] loads");
        ack_delay = 0;
        mem_word = 32'h8899AAFF;
        exp_mem_addr = 32'hC0;
        applyStimulus(OP_LB, 32'h0000_00C3, 32'h0, 32'h0000_00FF, 1'b0, 3, 1'b1, acc);
        waitResp(4);
        applyStimulus(OP_LH, 32'h0000_00C2, 32'h0, 32'h0000_AAFF, 1'b0, 3, 1'b1, acc);
        waitResp(5);
        applyStimulus(OP_LW, 32'h0000_00C0, 32'h0, 32'h8899AAFF, 1'b0, 3, 1'b1, acc);
        waitResp(6);

        $display("[TB] LW timeout");
        ack_rd_en = 1'b0;
        rd0 = rd_cycles;
        applyStimulus(OP_LW, 32'h0000_0100, 32'h0, 32'h0, 1'b1, TO + 2, 1'b1, acc);
        waitResp(7);
        checkOutput("to_rd_cycles", 32'(rd_cycles - rd0), 32'(TO));
        checkOutput("to_rd_dropped", 32'(mem_bus.mem_rd), 32'd0);
        ack_rd_en = 1'b1;

        $display("[TB] illegal op");
        rd0 = rd_cycles; wr0 = wr_cycles;
        applyStimulus(3'd7, 32'h0000_0200, 32'h1, 32'h0, 1'b1, 2, 1'b1, acc);
        waitResp(8);
        checkOutput("ill_no_rd", 32'(rd_cycles - rd0), 32'd0);
        checkOutput("ill_no_wr", 32'(wr_cycles - wr0), 32'd0);

        $display("[TB] reset during SH write");
        ack_wr_en = 1'b0;
        mem_word = 32'h55667788;
        exp_mem_addr = 32'h20;
        wa0 = wr_acks;
        rt0 = resp_total;
        applyStimulus(OP_SH, 32'h0000_0020, 32'h0000_9999, 32'h0, 1'b0, 0, 1'b0, acc);
        guard = 0;
        while (!mem_bus.mem_wr && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_mid_in_wr", 32'(mem_bus.mem_wr), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstmid_wr", 32'(mem_bus.mem_wr), 32'd0);
        checkOutput("rstmid_rd", 32'(mem_bus.mem_rd), 32'd0);
        checkOutput("rstmid_ready", 32'(req_bus.req_ready), 32'd1);
        checkOutput("rstmid_addr", mem_bus.mem_addr, 32'd0);
        checkOutput("rstmid_wdata", mem_bus.mem_wdata, 32'd0);
        checkOutput("rstmid_resp", 32'(req_bus.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rstmid_no_resp", 32'(resp_total - rt0), 32'd0);
        checkOutput("rstmid_no_write", 32'(wr_acks - wa0), 32'd0);

        $display("[TB] back-to-back loads");
        ack_wr_en = 1'b1;
        applyStimulus(OP_LW, 32'h0000_0021, 32'h0, 32'h55667788, 1'b0, 3, 1'b1, acc);
        applyStimulus(OP_LB, 32'h0000_0020, 32'h0, 32'h0000_0088, 1'b0, 3, 1'b1, acc2);
        checkOutput("b2b_accept_gap", 32'(acc2 - acc), 32'd3);
        waitResp(rt0 + 2);
        checkOutput("scoreboard_empty", 32'(resp_q.size() + write_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
